// File: rtl/lap_mem_reader.sv
// Streaming read engine: fetches a contiguous run of words from the lap-time RAM
// read port and presents them on a valid/ready stream, hiding the 1-cycle RAM latency.
module lap_mem_reader #(
  parameter int RAM_WIDTH     = 16,
  parameter int RAM_ADDR_BITS = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [RAM_ADDR_BITS-1:0] base_addr,
  input  logic [RAM_ADDR_BITS:0]   count,
  output logic                     busy,
  output logic                     done,
  output logic [RAM_ADDR_BITS-1:0] rd_addr,
  input  logic [RAM_WIDTH-1:0]     rd_data,
  output logic [RAM_WIDTH-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               dbg_state
);

  // Stream handshake: a word moves when out_valid && out_ready at a rising edge;
  // out_valid never depends on out_ready, and out_data holds while stalled.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [RAM_ADDR_BITS:0]   CNT_ONE  = 1;
  localparam logic [RAM_ADDR_BITS:0]   CNT_ZERO = '0;
  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = 1;

  logic [1:0]               state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [RAM_ADDR_BITS:0]   iss_q, iss_d;
  logic [RAM_ADDR_BITS:0]   acc_q, acc_d;
  logic                     inflight_q, inflight_d;
  logic                     done_q, done_d;
  logic [1:0]               occ_q, occ_d;
  logic [1:0]               wr_ptr_q, wr_ptr_d;
  logic [1:0]               rd_ptr_q, rd_ptr_d;
  logic [RAM_WIDTH-1:0]     fifo_q [0:2];

  logic issue;
  logic push;
  logic pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    ptr_inc = (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts words already buffered plus the read whose data arrives next cycle.
  assign issue = (state_q == S_RUN) && (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
  assign push  = inflight_q;
  assign pop   = (occ_q != 2'd0) && out_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    iss_d      = iss_q;
    acc_d      = acc_q;
    inflight_d = issue;
    done_d     = 1'b0;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    if (issue) begin
      iss_d = iss_q - CNT_ONE;
      // Address stops on the last word so rd_addr only ever shows requested words.
      if (iss_q == CNT_ONE) begin
        state_d = S_DRAIN;
      end else begin
        addr_d = addr_q + ADDR_ONE;
      end
    end

    if (pop) begin
      acc_d = acc_q - CNT_ONE;
      if (state_q == S_DRAIN && acc_q == CNT_ONE) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    if (state_q == S_IDLE && start) begin
      iss_d = count;
      acc_d = count;
      if (count != CNT_ZERO) begin
        state_d = S_RUN;
        addr_d  = base_addr;
      end else begin
        done_d = 1'b1;
      end
    end

    if (abort) begin
      state_d    = S_IDLE;
      iss_d      = CNT_ZERO;
      acc_d      = CNT_ZERO;
      inflight_d = 1'b0;
      done_d     = 1'b0;
      occ_d      = 2'd0;
      wr_ptr_d   = 2'd0;
      rd_ptr_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      iss_q      <= '0;
      acc_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      iss_q      <= iss_d;
      acc_q      <= acc_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      fifo_q[2] <= '0;
    end else if (push && !abort) begin
      fifo_q[wr_ptr_q] <= rd_data;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign rd_addr   = addr_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = fifo_q[rd_ptr_q];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lap_mem_reader.sv
// Bench for lap_mem_reader: behavioural RAM plus a word-list reference model
// (expected words are mem[(base+i) mod depth]) checked against the delivered stream.
module tb_lap_mem_reader;

  localparam int W     = 16;
  localparam int AB    = 9;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AB-1:0] base_addr;
  logic [AB:0]   count;
  logic          busy;
  logic          done;
  logic [AB-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    dbg_state;

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  exp_q [$];
  logic [W-1:0]  got_q [$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            done_cnt = 0;

  lap_mem_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // ---------------- clock / RAM / monitor ----------------
  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (done) done_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic load_exp(input int b, input int c);
    for (int i = 0; i < c; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
  endtask

  task automatic do_start(input int b, input int c);
    start     = 1'b1;
    base_addr = AB'(b);
    count     = (AB + 1)'(c);
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != 0) begin
        timed_out = 1'b0;
        break;
      end
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++; if (rd_addr !== '0)   begin n_fail++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
    n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== '0)  begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
  endtask

  task automatic test_zero_count();
    clear_obs();
    do_start(7, 0);
    n_cmp++; if (done !== 1'b1)      begin n_fail++; $display("FAIL zero_done got=%b exp=1", done); end
    n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL zero_busy got=%b exp=0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid got=%b exp=0", out_valid); end
    n_cmp++; if (rd_addr !== '0)     begin n_fail++; $display("FAIL zero_rd_addr got=%0d exp=0", rd_addr); end
    tick();
    n_cmp++; if (done !== 1'b0)      begin n_fail++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
    repeat (3) tick();
    n_cmp++; if (got_q.size() != 0)  begin n_fail++; $display("FAIL zero_words got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_latency();
    logic [W-1:0] exp_w;
    clear_obs();
    out_ready = 1'b1;
    do_start(10, 4);
    for (int k = 1; k <= 8; k++) begin
      n_cmp++; if (busy !== (k <= 6)) begin n_fail++; $display("FAIL lat_busy cyc=%0d got=%b exp=%b", k, busy, (k <= 6)); end
      n_cmp++; if (done !== (k == 7)) begin n_fail++; $display("FAIL lat_done cyc=%0d got=%b exp=%b", k, done, (k == 7)); end
      n_cmp++; if (out_valid !== (k >= 3 && k <= 6)) begin
        n_fail++; $display("FAIL lat_valid cyc=%0d got=%b exp=%b", k, out_valid, (k >= 3 && k <= 6));
      end
      if (k >= 3 && k <= 6) begin
        exp_w = W'(16'h100 + 10 + k - 3);
        n_cmp++; if (out_data !== exp_w) begin n_fail++; $display("FAIL lat_data cyc=%0d got=%h exp=%h", k, out_data, exp_w); end
      end
      if (k == 1) begin
        n_cmp++; if (rd_addr !== AB'(10)) begin n_fail++; $display("FAIL lat_first_addr got=%0d exp=10", rd_addr); end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    int addr_seq[$];
    int exp_a;
    bit to;
    clear_obs();
    load_exp(510, 4);
    do_start(510, 4);
    for (int i = 0; i < 40 && done_cnt == 0; i++) begin
      if (busy && (addr_seq.size() == 0 || addr_seq[addr_seq.size() - 1] != int'(rd_addr)))
        addr_seq.push_back(int'(rd_addr));
      tick();
    end
    wait_done(40, 1'b0, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL wrap_timeout got=no_done exp=done"); end
    n_cmp++; if (addr_seq.size() != 4) begin n_fail++; $display("FAIL wrap_addr_count got=%0d exp=4", addr_seq.size()); end
    for (int i = 0; i < addr_seq.size() && i < 4; i++) begin
      exp_a = (510 + i) % DEPTH;
      n_cmp++; if (addr_seq[i] != exp_a) begin n_fail++; $display("FAIL wrap_addr idx=%0d got=%0d exp=%0d", i, addr_seq[i], exp_a); end
    end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_words got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int offset;
    clear_obs();
    out_ready = 1'b1;
    load_exp(20, 16);
    do_start(20, 16);
    for (int k = 1; k <= 9; k++) begin
      if (k == 4) out_ready = 1'b0;
      if (k >= 4) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", k, out_valid); end
        n_cmp++; if (out_data !== mem[21]) begin n_fail++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", k, out_data, mem[21]); end
      end
      if (k == 9) begin
        offset = (int'(rd_addr) - 20 + DEPTH) % DEPTH;
        n_cmp++; if (offset > got_q.size() + 3) begin
          n_fail++; $display("FAIL bp_credit got=%0d exp<=%0d", offset, got_q.size() + 3);
        end
      end
      tick();
    end
    out_ready = 1'b1;
    wait_done(200, 1'b0, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL bp_timeout got=no_done exp=done"); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
    n_cmp++; if (got_q.size() != 16) begin n_fail++; $display("FAIL bp_words got=%0d exp=16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_while_busy();
    bit to;
    clear_obs();
    load_exp(50, 6);
    do_start(50, 6);
    tick();
    do_start(200, 3);
    wait_done(100, 1'b0, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL busy_start_timeout got=no_done exp=done"); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_start_done got=%0d exp=1", done_cnt); end
    n_cmp++; if (got_q.size() != 6) begin n_fail++; $display("FAIL busy_start_words got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_start_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    bit to;
    clear_obs();
    load_exp(30, 3);
    do_start(30, 8);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
    repeat (10) tick();
    n_cmp++; if (done_cnt != 0)      begin n_fail++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_idle_valid got=%b exp=0", out_valid); end
    n_cmp++; if (got_q.size() != 3) begin n_fail++; $display("FAIL abort_words got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL abort_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    clear_obs();
    do_start(0, 2);
    wait_done(50, 1'b0, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL abort_restart_timeout got=no_done exp=done"); end
    n_cmp++; if (got_q.size() != 2) begin n_fail++; $display("FAIL abort_restart_words got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      n_cmp++; if (got_q[i] !== W'(16'h100 + i)) begin
        n_fail++; $display("FAIL abort_restart_data idx=%0d got=%h exp=%h", i, got_q[i], W'(16'h100 + i));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_obs();
    do_start(5, 8);
    repeat (3) tick();
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (rd_addr !== '0)     begin n_fail++; $display("FAIL rstmid_rd_addr got=%0d exp=0", rd_addr); end
    n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_fail++; $display("FAIL rstmid_done got=%b exp=0", done); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== '0)    begin n_fail++; $display("FAIL rstmid_data got=%h exp=0", out_data); end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    n_cmp++; if (busy !== 1'b0 || done_cnt != 0) begin
      n_fail++; $display("FAIL rstmid_idle got=busy%b/done%0d exp=busy0/done0", busy, done_cnt);
    end
    clear_obs();
    load_exp(100, 3);
    do_start(100, 3);
    wait_done(50, 1'b0, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL rstmid_restart_timeout got=no_done exp=done"); end
    n_cmp++; if (got_q.size() != 3) begin n_fail++; $display("FAIL rstmid_words got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit to;
    int b;
    int c;
    for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom_range(0, 65535));
    for (int t = 0; t < 8; t++) begin
      clear_obs();
      b = $urandom_range(0, DEPTH - 1);
      c = (t == 0) ? 0 : (t == 7) ? DEPTH : $urandom_range(1, 24);
      load_exp(b, c);
      do_start(b, c);
      wait_done(4 * DEPTH, 1'b1, to);
      n_cmp++; if (to) begin n_fail++; $display("FAIL rnd_timeout t=%0d got=no_done exp=done", t); end
      n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL rnd_done t=%0d got=%0d exp=1", t, done_cnt); end
      n_cmp++; if (got_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rnd_words t=%0d got=%0d exp=%0d", t, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_cmp++; if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rnd_data t=%0d idx=%0d got=%h exp=%h", t, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    count     = '0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = W'(i + 16'h100);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    test_reset();
    test_zero_count();
    test_latency();
    test_wrap();
    test_backpressure();
    test_start_while_busy();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lap_mem_reader.md
# lap_mem_reader

Streaming read engine for the lap-time store. It sits on the read port of the dual-port block RAM: the chronometer writes lap records through the write port, and this block reads a contiguous run of them back. On a start command it fetches `count` words beginning at `base_addr` and presents them on a valid/ready stream to the display/UART path. It absorbs the RAM's one-cycle read latency and any sink backpressure without losing or duplicating words.

## Interface
Parameters:
- RAM_WIDTH, 16, data word width (matches the RAM)
- RAM_ADDR_BITS, 9, RAM address width; depth = 2**RAM_ADDR_BITS

Ports:
- clk  in  1  single clock, rising edge; same clock as the RAM
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- abort  in  1  cancel current transfer, any state
- base_addr  in  RAM_ADDR_BITS  first word address, captured on accepted start
- count  in  RAM_ADDR_BITS+1  number of words, 0..2**RAM_ADDR_BITS, captured on accepted start
- busy  out  1  high from the cycle after an accepted start until done or abort
- done  out  1  one-cycle pulse when the transfer completes
- rd_addr  out  RAM_ADDR_BITS  to RAM read address, registered
- rd_data  in  RAM_WIDTH  from RAM; valid the cycle after rd_addr is presented with a read issued
- out_data  out  RAM_WIDTH  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready; a word transfers when out_valid && out_ready at a rising edge

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 captures base_addr into the address counter and count into the issue and accept counters.
  - count≠0 → RUN.
  - count=0 → no reads; done pulses in the next cycle; busy stays 0.
- RUN: issues one read per cycle while the credit rule allows it.
  - Credit rule: (FIFO occupancy + reads in flight) < 3. Same-cycle pops are not counted.
  - Each issue increments the address mod 2**RAM_ADDR_BITS (511 → 0) and decrements the issue counter.
  - When the issue counter reaches 0 → DRAIN.
- Every issued read is captured from rd_data into a 3-entry FIFO one cycle after issue. out_data/out_valid show the FIFO head.
- DRAIN: when the accept counter reaches 0 (last handshake) → IDLE, with done=1 for one cycle and busy=0 in that same cycle.
- Backpressure: while out_valid=1 && out_ready=0, out_data is held stable. Occupancy plus in-flight reads never exceeds 3, so no word is dropped.
- abort=1, any state: next cycle IDLE, FIFO flushed, out_valid=0, in-flight read discarded, no done pulse. abort has priority over start.
- start while busy is ignored. The RAM is never written by this block.

## Timing
- Reset (async assert, sync release) values: state=IDLE, rd_addr=0, busy=0, done=0, out_valid=0, out_data=0, FIFO empty, all counters 0.
- Latency with out_ready=1, start sampled at edge 0:
  - cycle 1: busy=1, rd_addr=base (first issue)
  - cycle 2: rd_data=mem[base]
  - cycle 3: out_valid=1 with out_data=mem[base]
- Throughput: one word per cycle sustained while out_ready=1. N words occupy cycles 3..N+2; done pulses in cycle N+3.
- out_valid never drops between words while the FIFO is non-empty. A word is removed only on handshake.
- Reset asserted mid-transfer returns all state to reset values immediately. No done pulse.

## Test plan
- Preload mem[i]=i+0x100. start base=10, count=4, out_ready=1 → out_data 0x10A..0x10D in cycles 3..6; done in cycle 7; busy high cycles 1..6.
- base=510, count=4 → rd_addr sequence 510, 511, 0, 1; words 0x2FE, 0x2FF, 0x100, 0x101 in order.
- count=16 with out_ready low for cycles 4..9, then high → at most 3 reads issued beyond the accepted words; out_data stable while stalled; all 16 words delivered once, in order; done once.
- count=0 → no rd_addr change, out_valid stays 0, done pulses the cycle after start. start pulsed during a busy transfer → no effect on that transfer.
- abort in cycle 5 of a count=8 transfer → out_valid=0 and busy=0 next cycle, no done. A new start base=0, count=2 then delivers 0x100, 0x101 correctly.
- rst_n low mid-transfer → all outputs at reset values asynchronously; after release, module idle and accepts a new start.
